muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit. Serves MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//  REM/REMU in the execute stage beside the single-cycle ALU.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Both directions use valid/ready: a beat transfers on the rising edge where
// valid && ready are both high; the sender keeps its payload stable while
// valid is high and ready is low, and valid never drops before the transfer.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [2:0]      md_sel;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] res;

   // Execute stage side: issues requests and consumes results.
   modport master (
      output in_valid, op1, op2, md_sel, out_ready,
      input  in_ready, out_valid, res
   );

   // Unit side.
   modport slave (
      input  in_valid, op1, op2, md_sel, out_ready,
      output in_ready, out_valid, res
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle on operand magnitudes, with the sign applied in a final FIX cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus,
   output logic         busy,
   output logic [1:0]   fsm_state
);
   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [2:0]        sel_r;
   logic              sign1;
   logic              sign2;
   logic [XLEN-1:0]   mag1;       // multiplicand / dividend magnitude
   logic [XLEN-1:0]   mag2;       // multiplier / divisor magnitude
   logic [2*XLEN-1:0] acc;        // product accumulator
   logic [XLEN:0]     rem_r;      // one spare bit: a shifted partial remainder can reach 2*divisor-1
   logic [XLEN-1:0]   quo;
   logic [CW-1:0]     count;

   // Request decode: signedness, magnitudes and fast-path detection.
   logic              op1_signed;
   logic              op2_signed;
   logic              neg1;
   logic              neg2;
   logic [XLEN-1:0]   in_mag1;
   logic [XLEN-1:0]   in_mag2;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   fast_res;

   always_comb begin
      op1_signed = (bus.md_sel == OP_MULH) || (bus.md_sel == OP_MULHSU) ||
                   (bus.md_sel == OP_DIV)  || (bus.md_sel == OP_REM);
      op2_signed = (bus.md_sel == OP_MULH) || (bus.md_sel == OP_DIV) ||
                   (bus.md_sel == OP_REM);
      neg1       = op1_signed && bus.op1[XLEN-1];
      neg2       = op2_signed && bus.op2[XLEN-1];
      in_mag1    = neg1 ? (~bus.op1 + 1'b1) : bus.op1;
      in_mag2    = neg2 ? (~bus.op2 + 1'b1) : bus.op2;
      div_zero   = bus.md_sel[2] && (bus.op2 == '0);
      div_ovf    = ((bus.md_sel == OP_DIV) || (bus.md_sel == OP_REM)) &&
                   (bus.op1 == MIN_NEG) && (bus.op2 == ALL_ONES);
      fast_res   = '0;
      if (div_zero) begin
         fast_res = bus.md_sel[1] ? bus.op1 : ALL_ONES;
      end else if (div_ovf) begin
         fast_res = bus.md_sel[1] ? '0 : MIN_NEG;
      end
   end

   // One iteration step: shift-add for multiply, restoring step for divide.
   logic [CW-1:0]     bit_idx;
   logic [XLEN:0]     rem_shift;
   logic              rem_ge;
   logic [XLEN:0]     rem_next;
   logic [2*XLEN-1:0] acc_next;

   always_comb begin
      bit_idx   = CW'(XLEN - 1) - count;
      rem_shift = {rem_r[XLEN-1:0], mag1[bit_idx]};
      rem_ge    = rem_shift >= {1'b0, mag2};
      rem_next  = rem_ge ? (rem_shift - {1'b0, mag2}) : rem_shift;
      acc_next  = acc;
      if (mag2[count]) begin
         acc_next = acc + ({{XLEN{1'b0}}, mag1} << count);
      end
   end

   // Sign fix-up and result selection used in the FIX cycle.
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   fix_res;

   always_comb begin
      prod_fix = (sign1 ^ sign2) ? (~acc + 1'b1) : acc;
      quo_fix  = (sign1 ^ sign2) ? (~quo + 1'b1) : quo;
      rem_fix  = sign1 ? (~rem_r[XLEN-1:0] + 1'b1) : rem_r[XLEN-1:0];
      case (sel_r)
         3'b000:                 fix_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res = quo_fix;
         default:                fix_res = rem_fix;
      endcase
   end

   assign bus.in_ready = (state == IDLE);
   assign busy         = (state != IDLE);
   assign fsm_state    = state;

   // Control FSM plus datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.res       <= '0;
         sel_r         <= '0;
         sign1         <= 1'b0;
         sign2         <= 1'b0;
         mag1          <= '0;
         mag2          <= '0;
         acc           <= '0;
         rem_r         <= '0;
         quo           <= '0;
         count         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sel_r <= bus.md_sel;
                  sign1 <= neg1;
                  sign2 <= neg2;
                  mag1  <= in_mag1;
                  mag2  <= in_mag2;
                  acc   <= '0;
                  rem_r <= '0;
                  quo   <= '0;
                  count <= '0;
                  if (div_zero || div_ovf) begin
                     bus.res       <= fast_res;
                     bus.out_valid <= 1'b1;
                     state         <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (sel_r[2]) begin
                  rem_r <= rem_next;
                  quo   <= {quo[XLEN-2:0], rem_ge};
               end else begin
                  acc <= acc_next;
               end
               count <= count + 1'b1;
               if (count == CW'(XLEN - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               bus.res       <= fix_res;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            default: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic
// RV32M reference model.
module tb_muldiv_unit;
   logic       clk;
   logic       rst;
   logic       busy;
   logic [1:0] fsm_state;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model straight from the RV32M definitions.
   function automatic logic [31:0] ref_model(input logic [2:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      int              ia, ib;
      logic [31:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = $signed(a);
      ib = $signed(b);
      r  = 32'h0;
      case (sel)
         3'd0: begin up = ua * ub; r = up[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin up = ua * ub; r = up[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = ia / ib;
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = ia % ib;
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_fast(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
      return sel[2] && ((b == 0) ||
             ((sel == 3'd4 || sel == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Driver: issue one request, measure latency, optionally stall the result,
   // then score the returned value and the return to idle.
   task automatic do_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
      int          lat;
      int          wait_cyc;
      logic [31:0] first_res;
      exp_q.push_back(ref_model(sel, a, b));
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.op1       = a;
      bus.op2       = b;
      bus.md_sel    = sel;
      bus.out_ready = (hold == 0);
      wait_cyc = 0;
      while (!bus.in_ready && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("accept_wait", 32'(wait_cyc < 100), 32'd1);
      @(negedge clk);
      lat = 1;
      bus.in_valid = 1'b0;
      bus.op1      = $urandom;
      bus.op2      = $urandom;
      bus.md_sel   = 3'($urandom_range(0, 7));
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), is_fast(sel, a, b) ? 32'd1 : 32'd34);
      first_res = bus.res;
      for (int i = 0; i < hold; i++) begin
         check("hold_res", bus.res, first_res);
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      check("result", bus.res, exp_q.pop_front());
      @(negedge clk);
      check("valid_clear", 32'(bus.out_valid), 32'd0);
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.op1       = '0;
      bus.op2       = '0;
      bus.md_sel    = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_res", bus.res, 32'h0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);

      // directed cases
      do_op(3'd0, 32'd6, 32'd5, 0);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(3'd5, 32'd100, 32'd7, 0);
      do_op(3'd7, 32'd100, 32'd7, 0);
      do_op(3'd4, 32'd5, 32'd0, 0);
      do_op(3'd7, 32'h1234, 32'd0, 0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5);

      // reset in the middle of an iteration
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op1      = 32'd1234;
      bus.op2      = 32'd5678;
      bus.md_sel   = 3'd0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_res", bus.res, 32'h0);
      check("mid_rst_state", 32'(fsm_state), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      do_op(3'd0, 32'd3, 32'd3, 0);

      // randomized operations
      for (int n = 0; n < 60; n++) begin
         do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), $urandom_range(0, 3));
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
